uart_pattern_gen: RTL and testbench
===================================

// Module: uart_pattern_gen
// PURPOSE
//  Parametrised paced test-pattern source for the UART TX path. Emits one word per frame
//  period on a valid/ready stream into uart_tx. Runtime-selectable pattern (count, constant,
//  LFSR, count+LF). Replaces the hard-wired 9600 baud / 100 MHz counter source in the top level.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency
//  BIT_RATE    9600         line rate; GAP_CLKS = CLK_HZ/BIT_RATE*FRAME_BITS (integer divide first)
//  FRAME_BITS  10           line bits per word (start+data+stop)
//  DATA_W      8            word width
//  WRAP_MAX    100          last value of COUNT modes, then wrap to 0 (must be < 2**DATA_W)
//  LFSR_POLY   8'hB8        Galois feedback mask, DATA_W bits
//  LFSR_SEED   8'h01        LFSR reset/reload value, non-zero
//  CNT_W       16           frame counter width
// PORTS
//  clk_i        in   1        system clock
//  nreset_i     in   1        asynchronous active-low reset
//  en_i         in   1        generator enable
//  mode_i       in   2        0 COUNT, 1 CONST, 2 LFSR, 3 COUNT_LF
//  const_i      in   DATA_W   word for CONST mode
//  tx_data_o    out  DATA_W   word to uart_tx, stable while tx_valid_o && !tx_ready_i
//  tx_valid_o   out  1        word offered
//  tx_ready_i   in   1        uart_tx accepts; transfer = valid && ready on a rising edge
//  frame_cnt_o  out  CNT_W    accepted words, wraps modulo 2**CNT_W
//  busy_o       out  1        high in any state other than IDLE
// BEHAVIOUR
//  - Reset async on nreset_i low: state IDLE, tx_valid_o 0, tx_data_o 0, frame_cnt_o 0, busy_o 0,
//    pace counter 0, pend 0, value counter 0, LFSR = LFSR_SEED. Release synchronous to clk_i.
//  - Pace counter: width $clog2(GAP_CLKS+1); counts 0..GAP_CLKS-1 while en_i=1, held 0 when en_i=0.
//    tick = (pace == GAP_CLKS-1) && en_i. tick sets pend; pend does not accumulate (max 1).
//  - FSM: IDLE -> WAIT (en_i=1). WAIT -> OFFER when pend or tick: load tx_data_o, tx_valid_o<=1,
//    clear pend; tick at cycle N gives valid at N+1. OFFER -> on transfer: frame_cnt_o+1,
//    advance pattern; COUNT_LF at wrap -> OFFER_LF (tx_data_o=8'h0A, valid held); else WAIT
//    (en_i=1) or IDLE (en_i=0). OFFER_LF -> on transfer: frame_cnt_o+1; WAIT or IDLE.
//  - Pattern word at load time: COUNT/COUNT_LF = value counter; CONST = const_i; LFSR = lfsr reg.
//    mode_i/const_i sampled only at load; a change mid-offer affects the next word only.
//  - Advance on transfer only: value counter +1, wraps to 0 after WAIT_MAX==WRAP_MAX; LFSR
//    shifts right, XOR LFSR_POLY when shifted-out bit is 1. Advance only the active mode's register.
//  - en_i low during OFFER/OFFER_LF: word not dropped; valid held until accepted, then IDLE.
//    en_i low in WAIT: IDLE next cycle, pend cleared. Counters keep value across en_i toggles.
//  - tx_ready_i ignored when tx_valid_o=0. Back-pressure longer than GAP_CLKS: one pend kept,
//    next word offered the cycle after transfer (WAIT->OFFER on pend), extra ticks lost.
//  - tx_valid_o never drops without a transfer, except on reset.
// STRUCTURE
//  - Package uart_pkg: mode encodings (MODE_COUNT..MODE_COUNT_LF), FSM state enum,
//    ASCII_LF = 8'h0A, function gap_clks(clk_hz, bit_rate, frame_bits).
//  - Sub-module uart_pace_timer (pace counter + tick), reusable by the rx baud path.
//    FSM, pattern registers and frame counter stay in this module.
// TESTING (CLK_HZ=1000, BIT_RATE=100, FRAME_BITS=10 -> GAP_CLKS=100; WRAP_MAX=3)
//  - Reset mid-OFFER (nreset_i low 1 cycle) -> valid 0, data 0, frame_cnt 0 in that cycle.
//  - COUNT, ready=1, en_i rises at t0 -> valid pulses at t0+100,+200..; data 0,1,2,3,0,1.
//  - COUNT_LF, ready=1 -> data 0,1,2,3,0x0A,0,1; 0x0A offered the cycle after 3 is accepted.
//  - LFSR, seed 0x01, poly 0xB8 -> 0x01,0xB8,0x5C,0x2E; frame_cnt_o=4 after four transfers.
//  - ready=0 for 250 cycles on word 5 -> data and valid stable; word 6 offered cycle after transfer.
//  - en_i low while valid&&!ready, mode_i 0->1 same cycle -> word kept, then IDLE; re-enable, CONST=0x55 -> 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART pattern source and its pace timer.
// Mode/state encodings, the line-feed word and the frame-gap helper.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT    = 2'd0,
        MODE_CONST    = 2'd1,
        MODE_LFSR     = 2'd2,
        MODE_COUNT_LF = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_OFFER    = 2'd2,
        ST_OFFER_LF = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Clocks per frame; the divide happens before the multiply on purpose.
    function automatic int gap_clks(input int clk_hz, input int bit_rate, input int frame_bits);
        return (clk_hz / bit_rate) * frame_bits;
    endfunction

endpackage

// File: rtl/uart_pace_timer.sv
// Free-running pace counter: one tick every GAP_CLKS cycles while enabled.
// Latency: tick is combinational from the count; no backpressure, held at 0 when disabled.
module uart_pace_timer #(
    parameter int GAP_CLKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int PW = $clog2(GAP_CLKS + 1);

    logic [PW-1:0] pace;
    logic          last;

    assign last = (pace == PW'(GAP_CLKS - 1));
    assign tick = last && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pace <= '0;
        end else if (!en || last) begin
            pace <= '0;
        end else begin
            pace <= pace + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pattern_gen.sv
// Paced test-pattern source feeding uart_tx over a valid/ready stream.
// Latency: word offered the cycle after the pace tick (or after the previous transfer if a tick is pending).
// Backpressure: word and valid held until accepted; at most one missed tick is remembered.
module uart_pattern_gen
    import uart_pkg::*;
#(
    parameter int                CLK_HZ     = 100_000_000,
    parameter int                BIT_RATE   = 9600,
    parameter int                FRAME_BITS = 10,
    parameter int                DATA_W     = 8,
    parameter int                WRAP_MAX   = 100,
    parameter logic [DATA_W-1:0] LFSR_POLY  = 8'hB8,
    parameter logic [DATA_W-1:0] LFSR_SEED  = 8'h01,
    parameter int                CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic              busy_o
);

    localparam int GAP_CLKS = gap_clks(CLK_HZ, BIT_RATE, FRAME_BITS);

    state_e            state, state_nxt;
    mode_e             cur_mode;
    logic              tick, pend, load, adv, xfer, at_wrap;
    logic [DATA_W-1:0] val, lfsr, word;

    uart_pace_timer #(.GAP_CLKS(GAP_CLKS)) u_pace (
        .clk   (clk_i),
        .rst_n (nreset_i),
        .en    (en_i),
        .tick  (tick)
    );

    assign xfer    = tx_valid_o && tx_ready_i;
    assign at_wrap = (val == DATA_W'(WRAP_MAX));
    assign busy_o  = (state != ST_IDLE);

    always_comb begin
        word = val;
        case (mode_e'(mode_i))
            MODE_CONST: word = const_i;
            MODE_LFSR:  word = lfsr;
            default:    word = val;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            ST_IDLE: if (en_i) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!en_i) begin
                    state_nxt = ST_IDLE;
                end else if (pend || tick) begin
                    load      = 1'b1;
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (xfer) begin
                    adv = 1'b1;
                    if (cur_mode == MODE_COUNT_LF && at_wrap) state_nxt = ST_OFFER_LF;
                    else                                     state_nxt = en_i ? ST_WAIT : ST_IDLE;
                end
            end
            ST_OFFER_LF: if (xfer) state_nxt = en_i ? ST_WAIT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state       <= ST_IDLE;
            cur_mode    <= MODE_COUNT;
            pend        <= 1'b0;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
            frame_cnt_o <= '0;
            val         <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            state <= state_nxt;

            // A tick is meaningless while disabled, so a stale pend never survives en_i low.
            if (load || !en_i) pend <= 1'b0;
            else if (tick)     pend <= 1'b1;

            if (load) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= word;
                cur_mode   <= mode_e'(mode_i);
            end else if (xfer) begin
                if (state_nxt == ST_OFFER_LF) tx_data_o  <= DATA_W'(ASCII_LF);
                else                          tx_valid_o <= 1'b0;
            end

            if (xfer) frame_cnt_o <= frame_cnt_o + 1'b1;

            if (adv) begin
                case (cur_mode)
                    MODE_COUNT, MODE_COUNT_LF: val <= at_wrap ? '0 : val + 1'b1;
                    MODE_LFSR: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Directed bench for uart_pattern_gen with a 100-cycle frame gap and WRAP_MAX=3.
module tb_uart_pattern_gen;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  const_val = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_pattern_gen #(
        .CLK_HZ     (1000),
        .BIT_RATE   (100),
        .FRAME_BITS (10),
        .DATA_W     (8),
        .WRAP_MAX   (3),
        .LFSR_POLY  (8'hB8),
        .LFSR_SEED  (8'h01),
        .CNT_W      (16)
    ) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .en_i        (en),
        .mode_i      (mode),
        .const_i     (const_val),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .frame_cnt_o (frame_cnt),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedges until valid is seen; -1 if the budget runs out.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < budget);
        if (!tx_valid) n = -1;
    endtask

    task automatic do_reset();
        en     = 1'b0;
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    int n;
    int changed;
    logic [7:0] cnt_exp [6]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01};
    logic [7:0] lf_exp  [7]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h00, 8'h01};
    int         lf_gap  [7]  = '{100, 100, 100, 100, 1, 99, 100};
    logic [7:0] lfsr_exp[4]  = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        nreset = 1'b1;

        // Reset asserted while a word is offered
        mode = 2'd0; tx_ready = 1'b0; en = 1'b1;
        wait_valid(200, n);
        chk("first_gap", n, 100);
        chk("offer_busy", 32'(busy), 1);
        nreset = 1'b0; en = 1'b0;
        #1;
        chk("midrst_valid", 32'(tx_valid), 0);
        chk("midrst_data", 32'(tx_data), 0);
        chk("midrst_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        nreset = 1'b1;

        // COUNT mode, always ready
        @(negedge clk);
        mode = 2'd0; tx_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(200, n);
            chk($sformatf("count_gap%0d", i), n, 100);
            chk($sformatf("count_data%0d", i), 32'(tx_data), 32'(cnt_exp[i]));
        end
        @(negedge clk);
        en = 1'b0;
        chk("count_cnt", 32'(frame_cnt), 6);
        @(negedge clk);
        @(negedge clk);
        chk("count_idle", 32'(busy), 0);

        // COUNT_LF mode: LF follows the wrap value immediately
        do_reset();
        mode = 2'd3; tx_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_valid(200, n);
            chk($sformatf("lf_gap%0d", i), n, lf_gap[i]);
            chk($sformatf("lf_data%0d", i), 32'(tx_data), 32'(lf_exp[i]));
        end
        @(negedge clk);
        chk("lf_cnt", 32'(frame_cnt), 7);

        // LFSR mode
        do_reset();
        mode = 2'd2; tx_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(200, n);
            chk($sformatf("lfsr_data%0d", i), 32'(tx_data), 32'(lfsr_exp[i]));
        end
        @(negedge clk);
        chk("lfsr_cnt", 32'(frame_cnt), 4);

        // Long backpressure on word 5; word 6 follows from the pending tick
        tx_ready = 1'b0;
        wait_valid(200, n);
        chk("stall_data", 32'(tx_data), 32'h17);
        changed = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h17) changed++;
        end
        chk("stall_stable", changed, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("post_xfer_valid", 32'(tx_valid), 0);
        @(negedge clk);
        chk("w6_valid", 32'(tx_valid), 1);
        chk("w6_data", 32'(tx_data), 32'hB3);
        chk("w6_cnt", 32'(frame_cnt), 5);

        // Disable mid-offer with a mode change: word kept, then IDLE, then CONST
        do_reset();
        mode = 2'd0; tx_ready = 1'b0; en = 1'b1;
        wait_valid(200, n);
        chk("hold_first", 32'(tx_data), 0);
        en = 1'b0; mode = 2'd1; const_val = 8'h55;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("hold_valid", 32'(tx_valid), 1);
        chk("hold_data", 32'(tx_data), 0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("hold_xfer_valid", 32'(tx_valid), 0);
        @(negedge clk);
        chk("hold_idle", 32'(busy), 0);
        chk("hold_cnt", 32'(frame_cnt), 1);
        en = 1'b1;
        wait_valid(250, n);
        chk("const_gap", n, 100);
        chk("const_data", 32'(tx_data), 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
